binary_to_octal_pulser: RTL
===========================

Name: binary_to_octal_pulser

Overview:
- Sequential inverse of the team's 8-to-3 octal_to_binary encoder.
- Accepts 3-bit binary codes through a valid/ready handshake and buffers one code.
- Drives the matching one-hot 8-bit line O for a programmable number of cycles, then a programmable gap of zeros.
- Sits in front of one-hot select/strobe consumers and in encoder loop-back benches (B -> O -> encoder -> B).

Parameters:
- HOLD_CYCLES, 2, cycles each one-hot code is driven on O; legal range 1..255.
- GAP_CYCLES, 1, cycles of all-zero O after each pulse; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- B  input  3  binary code, 0..7.
- in_valid  input  1  B is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- flush  input  1  synchronous abort; ends the current pulse and drops any buffered code.
- O  output  8  one-hot decoded output; bit B is set; all zeros when not driving.
- out_valid  output  1  high exactly while O is non-zero.
- busy  output  1  high when state != IDLE or the buffer is full.
- pulse_cnt  output  8  count of pulses that ran to completion; wraps 255 -> 0.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: O=8'h00, out_valid=0, pulse_cnt=0, busy=0, in_ready=1.
  - Internal: state=IDLE, buffer empty, counter=0.
  - Reset asserted mid-pulse clears O immediately, without waiting for a clock edge.
- Handshake and buffer:
  - in_ready = !buf_full, a pure function of registered state.
  - A transfer occurs on a rising edge when in_valid && in_ready. B is captured into the single-entry buffer and buf_full is set.
  - While in_ready=0, in_valid may be held high; B must be held stable. Nothing is captured and nothing is lost.
- State machine: states IDLE, DRIVE, GAP.
  - IDLE with buf_full: on the next edge, O <= 8'b1 << buf_code, out_valid <= 1, buf_full <= 0, cnt <= HOLD_CYCLES-1, next state DRIVE.
  - IDLE with buffer empty: stay in IDLE; O=0.
  - DRIVE with cnt != 0: cnt decrements and O holds.
  - DRIVE with cnt == 0: O <= 0, out_valid <= 0, pulse_cnt <= pulse_cnt+1. Next state is GAP with cnt <= GAP_CYCLES-1 if GAP_CYCLES > 0, otherwise IDLE.
  - GAP with cnt != 0: cnt decrements.
  - GAP with cnt == 0: next state IDLE.
- Timing:
  - Latency: a code accepted at edge k appears on O after edge k+1.
  - O stays high for exactly HOLD_CYCLES cycles.
  - Every pulse is followed by GAP_CYCLES zero cycles plus one IDLE cycle, so pulses never merge.
  - Period for back-to-back codes = HOLD_CYCLES + GAP_CYCLES + 1.
- Simultaneous events:
  - A new code may be accepted during DRIVE, GAP, or IDLE, provided the buffer is empty.
  - An accept in the same cycle that IDLE pops the buffer is impossible, because in_ready=0 that cycle.
- flush (synchronous, highest priority after reset):
  - Next edge: state=IDLE, O=0, out_valid=0, buffer emptied, cnt=0.
  - pulse_cnt is not incremented.
  - A handshake completing in the same cycle as flush is discarded.
- Width rules:
  - O is always either 0 or exactly one hot bit; never multi-hot.
  - The counter is 8 bits wide.
  - Out-of-range parameter values are a static configuration error. The bench must not use them.

Test Plan:
- Reset, then send B=3'd5 (defaults) -> O=8'b0010_0000 for 2 cycles starting one cycle after accept; then O=0; pulse_cnt=1.
- Sweep B=0..7 with in_valid held high -> O = 01, 02, 04, 08, 10, 20, 40, 80 in order, with a period of 4 cycles. in_ready drops while the buffer is full. pulse_cnt=8.
- HOLD_CYCLES=1, GAP_CYCLES=0, codes 3 then 6 -> O=08, 00, 40 on consecutive pulse slots (period 2). out_valid is never high on two adjacent cycles.
- Assert flush during the second cycle of DRIVE with a code buffered -> O=0 next edge; the buffered code is never driven; pulse_cnt unchanged; in_ready=1.
- Drop rst_n mid-pulse with O=8'h10 -> O=0 and pulse_cnt=0 asynchronously, without waiting for a clock edge. After release, B=3'd7 -> O=8'h80.
- Loop-back: feed O into the existing octal_to_binary encoder for all 8 codes -> the encoder output equals the B sent on every out_valid cycle.
- Wrap: issue 256 pulses -> pulse_cnt returns to 0.

Source files
------------

// File: rtl/binary_to_octal_pulser.sv
// binary_to_octal_pulser: takes 3-bit codes over valid/ready into a one-entry
// buffer and replays each as a one-hot pulse on O, HOLD_CYCLES wide, followed
// by GAP_CYCLES of zeros plus one idle cycle so consecutive pulses never merge.
module binary_to_octal_pulser #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] B,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] O,
  output logic       out_valid,
  output logic       busy,
  output logic [7:0] pulse_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  typedef struct packed {
    logic       full;
    logic [2:0] code;
  } buf_t;

  // Reload values for the shared down-counter; a zero gap skips GAP entirely.
  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_M1  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit         HAS_GAP = (GAP_CYCLES > 0);

  state_t     state, state_n;
  buf_t       buf_q, buf_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] o_q, o_n;
  logic       ov_q, ov_n;
  logic [7:0] pcnt_q, pcnt_n;
  logic       accept;

  // Ready depends only on registered state, never on in_valid.
  assign in_ready  = !buf_q.full;
  assign accept    = in_valid && in_ready;
  assign O         = o_q;
  assign out_valid = ov_q;
  assign pulse_cnt = pcnt_q;
  assign busy      = (state != IDLE) || buf_q.full;

  // Next-state, pulse output and buffer update; flush overrides everything.
  always_comb begin
    state_n = state;
    buf_n   = buf_q;
    cnt_n   = cnt;
    o_n     = o_q;
    ov_n    = ov_q;
    pcnt_n  = pcnt_q;
    unique case (state)
      IDLE: begin
        if (buf_q.full) begin
          o_n        = 8'b1 << buf_q.code;
          ov_n       = 1'b1;
          cnt_n      = HOLD_M1;
          buf_n.full = 1'b0;
          state_n    = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else begin
          o_n    = 8'h00;
          ov_n   = 1'b0;
          pcnt_n = pcnt_q + 8'd1;
          if (HAS_GAP) begin
            state_n = GAP;
            cnt_n   = GAP_M1;
          end else begin
            state_n = IDLE;
            cnt_n   = 8'd0;
          end
        end
      end
      GAP: begin
        if (cnt != 8'd0) cnt_n = cnt - 8'd1;
        else             state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        o_n     = 8'h00;
        ov_n    = 1'b0;
        cnt_n   = 8'd0;
      end
    endcase
    // A pop in IDLE and an accept are mutually exclusive: ready is low
    // whenever the buffer holds a code.
    if (accept) begin
      buf_n.full = 1'b1;
      buf_n.code = B;
    end
    if (flush) begin
      state_n    = IDLE;
      o_n        = 8'h00;
      ov_n       = 1'b0;
      cnt_n      = 8'd0;
      buf_n.full = 1'b0;
      pcnt_n     = pcnt_q;
    end
  end

  // State register; async reset clears O immediately, mid-pulse included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      buf_q  <= '0;
      cnt    <= 8'd0;
      o_q    <= 8'h00;
      ov_q   <= 1'b0;
      pcnt_q <= 8'd0;
    end else begin
      state  <= state_n;
      buf_q  <= buf_n;
      cnt    <= cnt_n;
      o_q    <= o_n;
      ov_q   <= ov_n;
      pcnt_q <= pcnt_n;
    end
  end

endmodule
